// File: rtl/health_tracker_pkg.sv
// Shared fighter types and defaults, also used by the HUD health bar and round control.
// Pure declarations: no latency and no flow control.
package fighter_pkg;

  localparam int HEALTH_W          = 7;
  localparam int INV_CNT_W         = 8;
  localparam int MAX_HEALTH_DEF    = 100;
  localparam int INVULN_FRAMES_DEF = 32;
  localparam int FLASH_PERIOD_DEF  = 4;

  typedef enum logic [1:0] {
    READY  = 2'd0,
    INVULN = 2'd1,
    KO     = 2'd2
  } health_state_t;

  // Health never wraps: any damage at or above the remaining health lands on zero.
  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] a,
                                                  input logic [HEALTH_W-1:0] b);
    return (b >= a) ? '0 : a - b;
  endfunction

endpackage

// File: rtl/health_tracker_if.sv
// Per-fighter link between hitbox/frame timing and the health tracker.
// Level signals sampled every Clk; there is no backpressure.
interface health_tracker_if;
  import fighter_pkg::*;

  logic                frame_tick;
  logic                round_start;
  logic                contact;
  logic                attack_active;
  logic [HEALTH_W-1:0] damage;
  logic [HEALTH_W-1:0] health;
  logic                hit;
  logic                flash;
  logic                ko;

  modport master (
    output frame_tick, round_start, contact, attack_active, damage,
    input  health, hit, flash, ko
  );

  modport slave (
    input  frame_tick, round_start, contact, attack_active, damage,
    output health, hit, flash, ko
  );

endinterface

// File: rtl/health_tracker_frame_down_counter.sv
// Loadable down-counter stepped by frame_tick, stopping at zero; load wins over a tick.
// Count updates one Clk after load/tick; tc_o flags the tick that takes the count from 1 to 0.
module frame_down_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         tick_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_nxt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_o  = 1'b0;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
      tc_o  = (cnt_q == W'(1));
    end
  end

  assign cnt_nxt_o = cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/health_tracker.sv
// Turns per-frame hitbox contact into health, hit pulse, blink and sticky KO for one fighter.
// All outputs registered, one Clk after the qualifying frame_tick; no backpressure.
module health_tracker
  import fighter_pkg::*;
#(
  parameter int MAX_HEALTH    = MAX_HEALTH_DEF,
  parameter int INVULN_FRAMES = INVULN_FRAMES_DEF,
  parameter int FLASH_PERIOD  = FLASH_PERIOD_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  health_tracker_if.slave  hif
);

  localparam logic [HEALTH_W-1:0]  MAX_H      = HEALTH_W'(MAX_HEALTH);
  localparam logic [INV_CNT_W-1:0] INV_LOAD   = INV_CNT_W'(INVULN_FRAMES);
  // FLASH_PERIOD is a power of two, so it is also the mask of the blink bit.
  localparam logic [INV_CNT_W-1:0] FLASH_MASK = INV_CNT_W'(FLASH_PERIOD);

  health_state_t       state_q, state_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic                hit_q, hit_d;
  logic                flash_q, flash_d;
  logic                ko_q, ko_d;
  logic                consumed_q, consumed_d;

  logic                 qual_hit;
  logic [HEALTH_W-1:0]  hit_health;
  logic                 inv_load;
  logic [INV_CNT_W-1:0] inv_load_val;
  logic [INV_CNT_W-1:0] inv_cnt_nxt;
  logic                 inv_tc;

  assign qual_hit   = (state_q == READY) && hif.frame_tick && hif.contact &&
                      hif.attack_active && !consumed_q;
  assign hit_health = sat_sub(health_q, hif.damage);

  // round_start clears the window; otherwise only a non-lethal hit arms it.
  assign inv_load     = hif.round_start || (qual_hit && (hit_health != '0));
  assign inv_load_val = hif.round_start ? '0 : INV_LOAD;

  frame_down_counter #(.W(INV_CNT_W)) u_inv_cnt (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .tick_i     (hif.frame_tick),
    .load_i     (inv_load),
    .load_val_i (inv_load_val),
    .cnt_nxt_o  (inv_cnt_nxt),
    .tc_o       (inv_tc)
  );

  always_comb begin
    state_d    = state_q;
    health_d   = health_q;
    hit_d      = 1'b0;
    ko_d       = ko_q;
    consumed_d = consumed_q && hif.attack_active;
    if (hif.round_start) begin
      health_d   = MAX_H;
      state_d    = READY;
      ko_d       = 1'b0;
      consumed_d = hif.attack_active;
    end else if (qual_hit) begin
      health_d   = hit_health;
      hit_d      = 1'b1;
      consumed_d = 1'b1;
      if (hit_health == '0) begin
        state_d = KO;
        ko_d    = 1'b1;
      end else begin
        state_d = INVULN;
      end
    end else if ((state_q == INVULN) && inv_tc) begin
      state_d = READY;
    end
    flash_d = (state_d == INVULN) && ((inv_cnt_nxt & FLASH_MASK) != '0);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= READY;
      health_q   <= MAX_H;
      hit_q      <= 1'b0;
      flash_q    <= 1'b0;
      ko_q       <= 1'b0;
      consumed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      health_q   <= health_d;
      hit_q      <= hit_d;
      flash_q    <= flash_d;
      ko_q       <= ko_d;
      consumed_q <= consumed_d;
    end
  end

  assign hif.health = health_q;
  assign hif.hit    = hit_q;
  assign hif.flash  = flash_q;
  assign hif.ko     = ko_q;

endmodule

// File: tb/tb_health_tracker.sv
// Directed scenarios followed by random traffic, each Clk checked against a frame-level model.
module tb_health_tracker;

  localparam int MAXH  = 100;
  localparam int INVF  = 32;
  localparam int FLASH = 4;

  logic Clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  // Reference model: health points, frames of invulnerability left, attack already used.
  int m_health;
  int m_inv;
  bit m_ko;
  bit m_used;
  bit m_hit;
  bit m_flash;

  health_tracker_if hif();

  health_tracker dut (
    .Clk   (Clk),
    .Reset (rst_n),
    .hif   (hif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic model(input bit rst, input bit ft, input bit rs, input bit ct,
                       input bit aa, input int dmg);
    m_hit = 1'b0;
    if (!rst) begin
      m_health = MAXH; m_inv = 0; m_ko = 1'b0; m_used = 1'b0;
    end else if (rs) begin
      m_health = MAXH; m_inv = 0; m_ko = 1'b0; m_used = aa;
    end else if (!m_ko && m_inv == 0 && ft && ct && aa && !m_used) begin
      m_hit  = 1'b1;
      m_used = 1'b1;
      m_health = (dmg >= m_health) ? 0 : m_health - dmg;
      if (m_health == 0) m_ko = 1'b1;
      else               m_inv = INVF;
    end else begin
      if (!aa) m_used = 1'b0;
      if (ft && m_inv > 0) m_inv = m_inv - 1;
    end
    m_flash = (m_inv > 0) && (((m_inv / FLASH) % 2) == 1);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit ft, input bit rs, input bit ct,
                      input bit aa, input int dmg);
    rst_n             = rst;
    hif.frame_tick    = ft;
    hif.round_start   = rs;
    hif.contact       = ct;
    hif.attack_active = aa;
    hif.damage        = 7'(dmg);
    @(posedge Clk);
    model(rst, ft, rs, ct, aa, dmg);
    #1;
    chk("health", 32'(hif.health), 32'(m_health));
    chk("hit",    32'(hif.hit),    32'(m_hit));
    chk("flash",  32'(hif.flash),  32'(m_flash));
    chk("ko",     32'(hif.ko),     32'(m_ko));
  endtask

  task automatic frame(input bit ct, input bit aa, input int dmg);
    step(1'b1, 1'b1, 1'b0, ct, aa, dmg);
    step(1'b1, 1'b0, 1'b0, ct, aa, dmg);
  endtask

  initial begin
    bit aa_r;
    n_assert = 0;
    n_fail   = 0;
    m_health = MAXH; m_inv = 0; m_ko = 1'b0; m_used = 1'b0; m_hit = 1'b0; m_flash = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10);
    chk("reset_health", 32'(hif.health), 32'd100);

    // First hit: exactly one hit pulse, then a held overlap lands nothing more
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10);
    chk("first_hit", 32'(hif.hit), 32'd1);
    chk("first_health", 32'(hif.health), 32'd90);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10);
    chk("hit_one_clk", 32'(hif.hit), 32'd0);
    repeat (99) frame(1'b1, 1'b1, 10);
    chk("held_attack", 32'(hif.health), 32'd90);
    frame(1'b0, 1'b0, 10);
    frame(1'b1, 1'b1, 10);
    chk("second_attack", 32'(hif.health), 32'd80);

    // Lethal hit saturates at zero and KO is absorbing
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    frame(1'b1, 1'b1, 95);
    chk("health_5", 32'(hif.health), 32'd5);
    repeat (33) frame(1'b0, 1'b0, 0);
    frame(1'b1, 1'b1, 20);
    chk("ko_health", 32'(hif.health), 32'd0);
    chk("ko_flag", 32'(hif.ko), 32'd1);
    repeat (4) begin
      frame(1'b0, 1'b0, 20);
      frame(1'b1, 1'b1, 20);
    end
    chk("ko_sticky", 32'(hif.health), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("round_health", 32'(hif.health), 32'd100);
    chk("round_ko", 32'(hif.ko), 32'd0);

    // round_start beats a simultaneous hit and blocks the attack in flight
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10);
    chk("rs_no_hit", 32'(hif.hit), 32'd0);
    repeat (40) frame(1'b1, 1'b1, 10);
    chk("inflight_blocked", 32'(hif.health), 32'd100);
    frame(1'b0, 1'b0, 10);
    frame(1'b1, 1'b1, 10);
    chk("rearmed_hit", 32'(hif.health), 32'd90);

    // Contact between frames, then a zero-damage hit
    repeat (33) frame(1'b0, 1'b0, 0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 50);
    chk("no_tick", 32'(hif.health), 32'd90);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    chk("zero_dmg_hit", 32'(hif.hit), 32'd1);
    chk("zero_dmg_health", 32'(hif.health), 32'd90);

    // Reset in the middle of the invulnerability window
    repeat (15) frame(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("midinv_reset", 32'(hif.health), 32'd100);
    chk("midinv_flash", 32'(hif.flash), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7);
    chk("ready_after_reset", 32'(hif.hit), 32'd1);

    // Random traffic
    aa_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      bit ft, ct, rs, rst;
      int dmg;
      ft  = ($urandom_range(0, 2) == 0);
      ct  = 1'($urandom_range(0, 1));
      rs  = ($urandom_range(0, 199) == 0);
      rst = !($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 15) == 0) aa_r = ~aa_r;
      dmg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                        : int'($urandom_range(0, 15));
      step(rst, ft, rs, ct, aa_r, dmg);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
